// File: rtl/mips_defs.sv
// Shared MIPS pipeline definitions: reset vector, next-PC source codes, nop word.
package mips_defs;

  localparam logic [31:0] MIPS_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD      = 32'h0000_0000;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_BR  = 2'b01,
    NPC_J   = 2'b10,
    NPC_JR  = 2'b11
  } npc_sel_e;

  // Branch displacement in bytes: sign-extended word offset.
  function automatic logic [31:0] br_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/npc.sv
// Combinational next-PC selection for the fetch stage.
module npc
  import mips_defs::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] ifid_pc4,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc
);

  logic [31:0] pc_plus4;

  // Pick the next fetch address; branch/jump bases are the delay-slot address.
  always_comb begin
    pc_plus4 = pc + 32'd4;
    next_pc  = pc_plus4;
    case (npc_sel_e'(npc_sel))
      NPC_SEQ: next_pc = pc_plus4;
      NPC_BR:  next_pc = br_taken ? (ifid_pc4 + br_offset(imm16)) : pc_plus4;
      NPC_J:   next_pc = {ifid_pc4[31:28], instr_index, 2'b00};
      NPC_JR:  next_pc = jr_target;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: program counter, fetch fault check and IF/ID register.
module fetch_unit
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC = MIPS_RESET_PC,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] instr_index,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  input  logic [31:0] im_data,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic [31:0] ifid_pc8,
  output logic        ifid_exc
);

  localparam logic [31:0] PC_LAST = RESET_PC + 32'(4 * IM_WORDS) - 32'd4;

  logic [31:0] next_pc;
  logic        fault;

  npc u_npc (
    .pc          (pc),
    .ifid_pc4    (ifid_pc4),
    .npc_sel     (npc_sel),
    .br_taken    (br_taken),
    .imm16       (imm16),
    .instr_index (instr_index),
    .jr_target   (jr_target),
    .next_pc     (next_pc)
  );

  // Flag fetches that are misaligned or outside instruction memory.
  always_comb begin
    fault = (pc[1:0] != 2'b00) || (pc < RESET_PC) || (pc > PC_LAST);
  end

  // Advance PC and load IF/ID; the delay slot is always latched, never flushed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc         <= RESET_PC;
      ifid_instr <= '0;
      ifid_pc4   <= '0;
      ifid_pc8   <= '0;
      ifid_exc   <= 1'b0;
    end else if (!stall) begin
      pc         <= next_pc;
      ifid_instr <= fault ? NOP_WORD : im_data;
      ifid_pc4   <= pc + 32'd4;
      ifid_pc8   <= pc + 32'd8;
      ifid_exc   <= fault;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with a behavioural fetch-stage model.
module tb_fetch_unit;

  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam int unsigned WORDS = 4096;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [1:0]  npc_sel = 2'b00;
  logic        br_taken = 1'b0;
  logic [15:0] imm16 = '0;
  logic [25:0] instr_index = '0;
  logic [31:0] jr_target = '0;
  logic [31:0] pc;
  logic [31:0] im_data;
  logic [31:0] ifid_instr, ifid_pc4, ifid_pc8;
  logic        ifid_exc;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_unit #(.RESET_PC(BASE), .IM_WORDS(WORDS)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .npc_sel     (npc_sel),
    .br_taken    (br_taken),
    .imm16       (imm16),
    .instr_index (instr_index),
    .jr_target   (jr_target),
    .pc          (pc),
    .im_data     (im_data),
    .ifid_instr  (ifid_instr),
    .ifid_pc4    (ifid_pc4),
    .ifid_pc8    (ifid_pc8),
    .ifid_exc    (ifid_exc)
  );

  always #5 clk = ~clk;

  // Instruction memory contents; out-of-window reads return recognisable junk.
  logic [31:0] mem [WORDS];

  function automatic bit in_window(input logic [31:0] a);
    longint unsigned la = a;
    return (a[1:0] == 2'b00) && (la >= BASE) && (la <= longint'(BASE) + 4 * WORDS - 4);
  endfunction

  function automatic logic [31:0] imem(input logic [31:0] a);
    if (in_window(a)) return mem[(a - BASE) / 4];
    return a ^ 32'hA5A5_5A5A;
  endfunction

  always_comb im_data = imem(pc);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] pc8;
    logic        exc;
  } exp_t;

  exp_t q[$];

  // Model state: the architectural view of PC and the IF/ID register.
  logic [31:0] m_pc, m_instr, m_pc4, m_pc8;
  logic        m_exc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = BASE; m_instr = '0; m_pc4 = '0; m_pc8 = '0; m_exc = 1'b0;
  endtask

  // Drive one cycle of ID control at the falling edge and queue the state
  // expected after the following rising edge.
  task automatic step(input logic st, input logic [1:0] sel, input logic bt,
                      input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] jr);
    logic [31:0] nxt;
    bit          bad;
    stall = st; npc_sel = sel; br_taken = bt; imm16 = imm; instr_index = idx; jr_target = jr;
    if (!st) begin
      bad = !in_window(m_pc);
      if (sel == 2'd1 && bt)  nxt = m_pc4 + 32'(int'($signed(imm)) * 4);
      else if (sel == 2'd2)   nxt = {m_pc4[31:28], 28'(idx) * 28'd4};
      else if (sel == 2'd3)   nxt = jr;
      else                    nxt = m_pc + 32'd4;
      m_instr = bad ? 32'h0 : mem[(m_pc - BASE) / 4];
      m_exc   = bad;
      m_pc4   = m_pc + 32'd4;
      m_pc8   = m_pc + 32'd8;
      m_pc    = nxt;
    end
    q.push_back('{m_pc, m_instr, m_pc4, m_pc8, m_exc});
    @(negedge clk);
  endtask

  task automatic seq(); step(1'b0, 2'd0, 1'b0, '0, '0, '0); endtask
  task automatic jr_to(input logic [31:0] t); step(1'b0, 2'd3, 1'b0, '0, '0, t); endtask

  // Monitor: after each rising edge compare the DUT with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc", pc, e.pc);
        chk("ifid_instr", ifid_instr, e.instr);
        chk("ifid_pc4", ifid_pc4, e.pc4);
        chk("ifid_pc8", ifid_pc8, e.pc8);
        chk("ifid_exc", 32'(ifid_exc), 32'(e.exc));
      end
    end
  end

  initial begin
    logic [31:0] t;
    int unsigned k;
    for (int i = 0; i < int'(WORDS); i++) mem[i] = $urandom;

    // Reset values
    #1 reset = 1'b1;
    #1;
    chk("rst_pc", pc, BASE);
    chk("rst_instr", ifid_instr, 32'h0);
    chk("rst_pc4", ifid_pc4, 32'h0);
    chk("rst_pc8", ifid_pc8, 32'h0);
    chk("rst_exc", 32'(ifid_exc), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Sequential fetch, then branch back from delay slot 3008
    seq(); seq();
    step(1'b0, 2'd1, 1'b1, 16'hFFFE, '0, '0);
    seq();
    // j from ifid_pc4=3004, then jr
    step(1'b0, 2'd2, 1'b0, '0, 26'h0000C10, '0);
    jr_to(32'h0000_3100);
    // Branch not taken
    step(1'b0, 2'd1, 1'b0, 16'hFFFE, '0, '0);
    // Stall two cycles with a pending jump, then take it
    step(1'b1, 2'd2, 1'b1, '0, 26'h0000C40, '0);
    step(1'b1, 2'd2, 1'b1, '0, 26'h0000C40, '0);
    step(1'b0, 2'd2, 1'b0, '0, 26'h0000C40, '0);
    // Faults: misaligned, beyond window, below window, last valid word
    jr_to(32'h0000_3002); seq();
    jr_to(32'h0000_7000); seq();
    jr_to(32'h0000_2FFC); seq();
    jr_to(32'h0000_6FFC); seq(); seq();
    // Wrap-around of pc+4
    jr_to(32'hFFFF_FFFC); seq(); seq();
    jr_to(BASE); seq();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, WORDS - 1);
      t = BASE + 32'(4 * k);
      if ($urandom_range(0, 9) == 0) t = $urandom;
      step(($urandom_range(0, 4) == 0), 2'($urandom_range(0, 3)), 1'($urandom),
           16'($signed(7'($urandom))), t[27:2], t);
    end
    jr_to(BASE + 32'h40);

    // Asynchronous reset mid-cycle during a taken branch
    step(1'b0, 2'd0, 1'b0, '0, '0, '0);
    npc_sel = 2'd1; br_taken = 1'b1; imm16 = 16'h0010;
    #2 reset = 1'b1;
    #1;
    chk("areset_pc", pc, BASE);
    chk("areset_instr", ifid_instr, 32'h0);
    chk("areset_pc4", ifid_pc4, 32'h0);
    chk("areset_pc8", ifid_pc8, 32'h0);
    chk("areset_exc", 32'(ifid_exc), 32'h0);
    @(posedge clk);
    #1;
    chk("reset_hold_pc", pc, BASE);
    @(negedge clk);
    stall = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_over_stall_pc", pc, BASE);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int n = 0; n < 30; n++) begin
      k = $urandom_range(0, WORDS - 1);
      t = BASE + 32'(4 * k);
      step(($urandom_range(0, 4) == 0), 2'($urandom_range(0, 3)), 1'($urandom),
           16'($signed(5'($urandom))), t[27:2], t);
    end

    // Drain the scoreboard with a bounded wait
    for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge clk);
    #2;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the five-stage MIPS pipeline. Holds the program counter, drives the instruction-memory address, computes the next PC (sequential, branch, j/jal, jr) from control resolved in ID, and registers the fetched word into the IF/ID pipeline register. The ISA uses branch delay slots: a redirect never flushes IF/ID.

## Interface
Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset; base of instruction memory.
- IM_WORDS, 4096, instruction memory depth in words; valid fetch window is RESET_PC .. RESET_PC+4*IM_WORDS-4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- stall  in  1  hazard-unit hold; freezes PC and IF/ID.
- npc_sel  in  2  next-PC source from ID: 00 seq, 01 branch, 10 j/jal, 11 jr.
- br_taken  in  1  branch comparison result from ID; only meaningful with npc_sel=01.
- imm16  in  16  branch offset field of the instruction in ID.
- instr_index  in  26  jump target field of the instruction in ID.
- jr_target  in  32  forwarded rs value for jr/jalr.
- pc  out  32  current fetch address to instruction memory.
- im_data  in  32  word returned combinationally by instruction memory for pc.
- ifid_instr  out  32  registered instruction for ID.
- ifid_pc4  out  32  registered PC+4 of that instruction.
- ifid_pc8  out  32  registered PC+8 (link value for jal/jalr).
- ifid_exc  out  1  registered fetch-fault flag for the instruction in ID.

## Operation
- Fault check (combinational): fault = pc[1:0]!=0 or pc<RESET_PC or pc>RESET_PC+4*IM_WORDS-4. On fault, word latched into IF/ID is 32'h0000_0000 (nop) and ifid_exc=1; otherwise im_data, ifid_exc=0.
- Next PC (all arithmetic 32-bit, modulo 2^32):
  - 00: pc+4.
  - 01: br_taken ? ifid_pc4 + (sign_extend(imm16)<<2) : pc+4.
  - 10: {ifid_pc4[31:28], instr_index, 2'b00}.
  - 11: jr_target, unaltered (misalignment caught by next fetch's fault check).
- Branch/jump bases use ifid_pc4 (address of the delay slot), never pc.
- Delay slot: on any redirect, the instruction currently being fetched (the delay slot) is still latched into IF/ID normally.
- Undefined npc_sel combinations do not exist; all four codes are decoded.

## Timing
- Reset values: pc=RESET_PC; ifid_instr=0; ifid_pc4=0; ifid_pc8=0; ifid_exc=0. Asynchronous: outputs change on reset assertion without a clock edge.
- First fetch: cycle after reset deasserts, pc=RESET_PC; its word appears on ifid_instr one edge later.
- Latency: pc -> ifid_* is exactly one rising edge.
- Redirect latency: redirect presented in cycle N (instruction in ID) loads pc at edge ending N; target word in IF/ID at edge ending N+1.
- stall=1: pc and all ifid_* hold; npc_sel/br_taken ignored (ID instruction is also held and re-presents its redirect next cycle).
- stall and reset together: reset wins.
- Reset asserted mid-redirect: redirect discarded, pc=RESET_PC.
- Wrap-around: pc+4 from 32'hFFFF_FFFC gives 0; that address faults, no special handling.

## Structure
- Shared package (mips_defs): RESET_PC value, NPC_SEQ/NPC_BR/NPC_J/NPC_JR encodings, NOP word constant.
- One sub-module: npc, purely combinational next-PC selection (pc, ifid_pc4, npc_sel, br_taken, imm16, instr_index, jr_target -> next_pc). Fault check and registers stay in fetch_unit.

## Test plan
- Reset release, npc_sel=00, no stall for 3 edges -> pc 3000, 3004, 3008, 300C; ifid_pc4 trails by one edge (3004, 3008, 300C); ifid_pc8 = ifid_pc4+4.
- Branch in ID with ifid_pc4=3008, imm16=16'hFFFE, br_taken=1 -> next pc=3000; delay slot word at 3008 latched into IF/ID; br_taken=0 with same inputs -> pc=300C.
- j with ifid_pc4=3004, instr_index=26'h0000C10 -> next pc=0000_3040; jr with jr_target=0000_3100 -> next pc=0000_3100.
- stall=1 for 2 cycles with npc_sel=10 -> pc and ifid_* unchanged both cycles; after stall drops, jump taken on following edge.
- jr_target=0000_3002 -> pc=3002, next edge ifid_instr=0, ifid_exc=1; pc=0000_7000 (beyond window) -> same fault response.
- Assert reset asynchronously mid-cycle while npc_sel=01, br_taken=1 -> pc=3000 and ifid_* zero immediately, before next clock edge.
